// File: rtl/img_pixel_fifo.sv
// ============================================================================
//  Module      : img_pixel_fifo
//  Description : Pixel-to-byte serialiser feeding a single-clock show-ahead
//                byte FIFO for the image UART transmitter. Each 16-bit RGB565
//                pixel becomes two bytes (order set by HI_FIRST). EMPTY low
//                means a byte is available on DATA_OUT; RDREQ pops it.
//                Optional macro IMG_FIFO_OVF_EN adds OVF / DROP_CNT ports
//                that flag pixels offered while the serialiser is busy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_pixel_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter bit HI_FIRST   = 1'b1
) (
    input  logic                  SYS_CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic [15:0]           PIX_DATA,
    input  logic                  PIX_VALID,
    output logic                  PIX_READY,
    output logic [7:0]            DATA_OUT,
    output logic                  EMPTY,
    input  logic                  RDREQ,
    output logic [DEPTH_LOG2:0]   USEDW,
    output logic                  FULL
`ifdef IMG_FIFO_OVF_EN
    ,
    output logic                  OVF,
    output logic [15:0]           DROP_CNT
`endif
);

    localparam int                unsigned c_DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_USEDW_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B0   = 2'd1,
        S_B1   = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_pix_ready;
    logic [15:0]             r_hold;
    logic [7:0]              r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_usedw;
    logic                    r_empty;
    logic                    r_full;

    logic                    w_pop;
    logic                    w_full_eff;
    logic                    w_push;
    logic [7:0]              w_byte;
    logic [DEPTH_LOG2:0]     w_usedw_next;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_pop      = RDREQ & ~r_empty;
    assign w_full_eff = r_full & ~w_pop;
    assign w_push     = ((r_state == S_B0) || (r_state == S_B1)) & ~w_full_eff;

    // Pick the byte for the current serialiser phase.
    always_comb begin
        w_byte = r_hold[7:0];
        if ((r_state == S_B0) == HI_FIRST) begin
            w_byte = r_hold[15:8];
        end
    end

    // Fill level after this cycle's push/pop.
    always_comb begin
        w_usedw_next = r_usedw;
        if (w_push && !w_pop) begin
            w_usedw_next = r_usedw + c_USEDW_ONE;
        end else if (!w_push && w_pop) begin
            w_usedw_next = r_usedw - c_USEDW_ONE;
        end
    end

    // Serialiser: latch a pixel, then emit its two bytes, stalling while full.
    always_ff @(posedge SYS_CLK) begin
        if (RST || FLUSH) begin
            r_state     <= S_IDLE;
            r_pix_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PIX_VALID) begin
                        r_hold      <= PIX_DATA;
                        r_state     <= S_B0;
                        r_pix_ready <= 1'b0;
                    end
                end
                S_B0: begin
                    if (!w_full_eff) begin
                        r_state <= S_B1;
                    end
                end
                S_B1: begin
                    if (!w_full_eff) begin
                        r_state     <= S_IDLE;
                        r_pix_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_pix_ready <= 1'b1;
                end
            endcase
        end
    end

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge SYS_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge SYS_CLK) begin
        if (RST || FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_usedw <= w_usedw_next;
            r_empty <= (w_usedw_next == '0);
            r_full  <= (w_usedw_next == c_FULL_LEVEL);
        end
    end

    assign PIX_READY = r_pix_ready;
    assign DATA_OUT  = r_mem[r_rd_ptr];
    assign EMPTY     = r_empty;
    assign USEDW     = r_usedw;
    assign FULL      = r_full;

`ifdef IMG_FIFO_OVF_EN
    logic        r_ovf;
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = PIX_VALID & ~r_pix_ready;

    // Count pixels offered while busy; saturate and keep a sticky flag.
    always_ff @(posedge SYS_CLK) begin
        if (RST || FLUSH) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign OVF      = r_ovf;
    assign DROP_CNT = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_img_pixel_fifo.sv
// ============================================================================
//  Module      : tb_img_pixel_fifo
//  Description : Directed self-checking bench for img_pixel_fifo
//                (DEPTH_LOG2=10, HI_FIRST=1). Build with IMG_FIFO_OVF_EN
//                defined to exercise the drop counter as well.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_pixel_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  data_out;
    logic        empty;
    logic        rdreq;
    logic [10:0] usedw;
    logic        full;
`ifdef IMG_FIFO_OVF_EN
    logic        ovf;
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    img_pixel_fifo #(
        .DEPTH_LOG2 (10),
        .HI_FIRST   (1'b1)
    ) dut (
        .SYS_CLK   (clk),
        .RST       (rst),
        .FLUSH     (flush),
        .PIX_DATA  (pix_data),
        .PIX_VALID (pix_valid),
        .PIX_READY (pix_ready),
        .DATA_OUT  (data_out),
        .EMPTY     (empty),
        .RDREQ     (rdreq),
        .USEDW     (usedw),
        .FULL      (full)
`ifdef IMG_FIFO_OVF_EN
        ,
        .OVF       (ovf),
        .DROP_CNT  (drop_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Offer one pixel once the serialiser is free (bounded wait).
    task automatic push_pixel(input logic [15:0] value);
        int guard;
        guard = 0;
        while (!pix_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_ready_timeout: pix_ready=%b required 1", pix_ready);
        end
        pix_data  = value;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; pix_valid = 1'b0; rdreq = 1'b0; pix_data = '0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", empty); end
        n_checks++; if (usedw !== 11'd0) begin n_fail++; $display("FAIL reset_usedw: got %0d required 0", usedw); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b required 0", full); end
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", pix_ready); end
        // Start a transfer, then reset in the middle of it.
        pix_data = 16'h1234; pix_valid = 1'b1; tick(); pix_valid = 1'b0; tick();
        n_checks++; if (usedw !== 11'd1) begin n_fail++; $display("FAIL midxfer_usedw: got %0d required 1", usedw); end
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst2_empty: got %b required 1", empty); end
        n_checks++; if (usedw !== 11'd0) begin n_fail++; $display("FAIL rst2_usedw: got %0d required 0", usedw); end
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL rst2_ready: got %b required 1", pix_ready); end
        // Next cycle accepts a new pixel.
        pix_data = 16'hC3E7; pix_valid = 1'b1; tick(); pix_valid = 1'b0;
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL rst_accept_ready: got %b required 0", pix_ready); end
        tick();
        n_checks++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL rst_accept_data: got %h required c3", data_out); end
        tick();
        n_checks++; if (usedw !== 11'd2) begin n_fail++; $display("FAIL rst_accept_usedw: got %0d required 2", usedw); end
        do_flush();
    endtask

    task automatic test_push();
        pix_data = 16'hA55A; pix_valid = 1'b1; tick(); pix_valid = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL push_empty_p1: got %b required 1", empty); end
        tick();
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL push_first_byte: got %h required a5", data_out); end
        n_checks++; if (usedw !== 11'd1) begin n_fail++; $display("FAIL push_usedw1: got %0d required 1", usedw); end
        tick();
        n_checks++; if (usedw !== 11'd2) begin n_fail++; $display("FAIL push_usedw2: got %0d required 2", usedw); end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        n_checks++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL push_second_byte: got %h required 5a", data_out); end
        n_checks++; if (usedw !== 11'd1) begin n_fail++; $display("FAIL pop_usedw1: got %0d required 1", usedw); end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        n_checks++; if (usedw !== 11'd0) begin n_fail++; $display("FAIL pop_usedw0: got %0d required 0", usedw); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty: got %b required 1", empty); end
        do_flush();
    endtask

    task automatic test_fill();
        logic [15:0] pv;
        for (int i = 0; i < 512; i++) begin
            pv = 16'(i);
            push_pixel({pv[7:0] ^ 8'h3C, pv[7:0]});
        end
        tick(); tick();
        n_checks++; if (usedw !== 11'd1024) begin n_fail++; $display("FAIL fill_usedw: got %0d required 1024", usedw); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b required 1", full); end
        n_checks++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL fill_head: got %h required 3c", data_out); end
        // 513th pixel is latched but stalls for lack of space.
        push_pixel(16'hBEEF);
        tick(); tick(); tick();
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b required 0", pix_ready); end
        n_checks++; if (usedw !== 11'd1024) begin n_fail++; $display("FAIL stall_usedw: got %0d required 1024", usedw); end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        n_checks++; if (usedw !== 11'd1024) begin n_fail++; $display("FAIL fullpop_usedw: got %0d required 1024", usedw); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL fullpop_data: got %h required 00", data_out); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready: got %b required 0", pix_ready); end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop2_ready: got %b required 1", pix_ready); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullpop2_full: got %b required 1", full); end
        do_flush();
    endtask

    task automatic test_wrap();
        int pix_idx;
        int pop_idx;
        int cyc;
        logic [15:0] pv;
        logic [7:0]  exp_b;
        pix_idx = 0; pop_idx = 0; cyc = 0;
        while (pop_idx < 6000 && cyc < 40000) begin
            if (pix_ready && pix_idx < 3000) begin
                pix_data  = 16'(pix_idx);
                pix_valid = 1'b1;
                pix_idx++;
            end else begin
                pix_valid = 1'b0;
            end
            if ((cyc % 4) == 0 && !empty) begin
                pv    = 16'(pop_idx / 2);
                exp_b = ((pop_idx % 2) == 0) ? pv[15:8] : pv[7:0];
                n_checks++;
                if (data_out !== exp_b) begin
                    n_fail++;
                    $display("FAIL wrap_byte[%0d]: got %h required %h", pop_idx, data_out, exp_b);
                end
                rdreq = 1'b1;
                pop_idx++;
            end else begin
                rdreq = 1'b0;
            end
            tick();
            cyc++;
        end
        pix_valid = 1'b0; rdreq = 1'b0;
        n_checks++; if (pop_idx != 6000) begin n_fail++; $display("FAIL wrap_count: got %0d required 6000", pop_idx); end
        tick();
        n_checks++; if (usedw !== 11'd0) begin n_fail++; $display("FAIL wrap_residual: got %0d required 0", usedw); end
        do_flush();
    endtask

    task automatic test_empty_read();
        rdreq = 1'b1;
        repeat (10) tick();
        rdreq = 1'b0;
        n_checks++; if (usedw !== 11'd0) begin n_fail++; $display("FAIL underflow_usedw: got %0d required 0", usedw); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL underflow_empty: got %b required 1", empty); end
        push_pixel(16'h9A7B);
        tick();
        n_checks++; if (data_out !== 8'h9A) begin n_fail++; $display("FAIL underflow_rdptr: got %h required 9a", data_out); end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        n_checks++; if (data_out !== 8'h7B) begin n_fail++; $display("FAIL underflow_next: got %h required 7b", data_out); end
        do_flush();
        for (int i = 0; i < 19; i++) begin
            push_pixel(16'(i + 16'h0100));
        end
        tick(); tick();
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        n_checks++; if (usedw !== 11'd37) begin n_fail++; $display("FAIL preflush_usedw: got %0d required 37", usedw); end
        do_flush();
        n_checks++; if (usedw !== 11'd0) begin n_fail++; $display("FAIL flush_usedw: got %0d required 0", usedw); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b required 1", empty); end
        n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b required 1", pix_ready); end
    endtask

`ifdef IMG_FIFO_OVF_EN
    task automatic test_ovf();
        int acc;
        do_flush();
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_init: got %b required 0", ovf); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL drop_init: got %0d required 0", drop_cnt); end
        acc = 0;
        pix_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            pix_data = 16'(k);
            if (pix_ready) acc++;
            tick();
        end
        pix_valid = 1'b0;
        n_checks++; if (acc != 3) begin n_fail++; $display("FAIL ovf_accepts: got %0d required 3", acc); end
        n_checks++; if (drop_cnt !== 16'd6) begin n_fail++; $display("FAIL drop_cnt: got %0d required 6", drop_cnt); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", ovf); end
        do_flush();
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", ovf); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL drop_clear: got %0d required 0", drop_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_push();
        test_fill();
        test_wrap();
        test_empty_read();
`ifdef IMG_FIFO_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
